// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write queue sitting between the EXE/MEM pipeline register and the
//   data memory. Stores are captured and retired to memory one per cycle
//   whenever the memory port is not busy with a load. Loads are checked
//   against buffered stores: an exact hit is forwarded, and a partial overlap
//   stalls the pipeline until the conflicting entries have drained.
//
// Parameters
//   DEPTH   number of queue entries (power of two, 2..16)
//   ADDR_W  byte-address width used from EXE_MEM_Result
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   EXE_MEM_Result  effective address (low ADDR_W bits used)
//   EXE_MEM_Rt      store data
//   EXE_MEM_Byte    1 = byte access, 0 = word access
//   MemWrite        store request
//   MemRead         load request
//   SB_MemWrite     write strobe to data memory (head entry retiring)
//   SB_Address      head entry address, zero-extended to 32 bits
//   SB_Rt           head entry data
//   SB_Byte         head entry byte flag
//   Fwd_Hit         load satisfied from the buffer
//   Fwd_Data        forwarded load value
//   Load_Stall      load partially overlaps a buffered store
//   Store_Stall     queue full while a store is requested

module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXE_MEM_Result,
  input  logic [31:0] EXE_MEM_Rt,
  input  logic        EXE_MEM_Byte,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic        SB_MemWrite,
  output logic [31:0] SB_Address,
  output logic [31:0] SB_Rt,
  output logic        SB_Byte,
  output logic        Fwd_Hit,
  output logic [31:0] Fwd_Data,
  output logic        Load_Stall,
  output logic        Store_Stall
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic              valid_q [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [31:0]       data_q  [DEPTH];
  logic              byte_q  [DEPTH];

  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] req_addr;
  logic              do_enq;
  logic              do_drain;
  logic              search_en;

  // Address bits above ADDR_W alias in memory, so they are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^EXE_MEM_Result[31:ADDR_W];

  assign req_addr  = EXE_MEM_Result[ADDR_W-1:0];
  assign search_en = MemRead && !MemWrite;

  // Full check ignores a same-cycle drain: keeps the stall purely a function
  // of registered count and the request, with no path through the load search.
  assign Store_Stall = MemWrite && (count == FULL);
  assign do_enq      = MemWrite && !Store_Stall;

  // ---------------------------------------------------------------------------
  // Load search. Entries are walked oldest to youngest starting at head, so the
  // last match seen is the youngest one.
  // ---------------------------------------------------------------------------
  logic             found;
  logic [PTR_W-1:0] y_idx;
  logic [PTR_W-1:0] idx;
  logic             exact;
  logic             fwd_ok;

  always_comb begin
    found = 1'b0;
    y_idx = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx][ADDR_W-1:2] == req_addr[ADDR_W-1:2])) begin
        found = 1'b1;
        y_idx = idx;
      end
    end
  end

  assign exact = (addr_q[y_idx] == req_addr);
  // A word load cannot be built from a byte store alone; it must wait.
  assign fwd_ok = exact && (EXE_MEM_Byte || !byte_q[y_idx]);

  assign Fwd_Hit    = search_en && found && fwd_ok;
  assign Load_Stall = search_en && found && !fwd_ok;
  assign Fwd_Data   = !Fwd_Hit     ? 32'h0 :
                      EXE_MEM_Byte ? {24'h0, data_q[y_idx][7:0]} :
                                     data_q[y_idx];

  // ---------------------------------------------------------------------------
  // Drain: the memory port is free unless a load is actually using it. A
  // stalled load does not use it, which lets the conflict clear itself.
  // ---------------------------------------------------------------------------
  assign do_drain    = (count != '0) && (!MemRead || Load_Stall);
  assign SB_MemWrite = do_drain;
  assign SB_Address  = {{(32-ADDR_W){1'b0}}, addr_q[head_q]};
  assign SB_Rt       = data_q[head_q];
  assign SB_Byte     = byte_q[head_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        byte_q[i]  <= 1'b0;
      end
    end else begin
      // Enqueue and drain never target the same slot: a drain needs count>0
      // and an enqueue needs count<DEPTH, so head==tail cannot occur here.
      if (do_drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (do_enq) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= req_addr;
        data_q[tail_q]  <= EXE_MEM_Rt;
        byte_q[tail_q]  <= EXE_MEM_Byte;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (do_enq && !do_drain) begin
        count <= count + CNT_W'(1);
      end else if (!do_enq && do_drain) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] EXE_MEM_Result;
  logic [31:0] EXE_MEM_Rt;
  logic        EXE_MEM_Byte;
  logic        MemWrite;
  logic        MemRead;
  logic        SB_MemWrite;
  logic [31:0] SB_Address;
  logic [31:0] SB_Rt;
  logic        SB_Byte;
  logic        Fwd_Hit;
  logic [31:0] Fwd_Data;
  logic        Load_Stall;
  logic        Store_Stall;

  int vectors;
  int miscompares;

  store_buffer #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .EXE_MEM_Result (EXE_MEM_Result),
    .EXE_MEM_Rt     (EXE_MEM_Rt),
    .EXE_MEM_Byte   (EXE_MEM_Byte),
    .MemWrite       (MemWrite),
    .MemRead        (MemRead),
    .SB_MemWrite    (SB_MemWrite),
    .SB_Address     (SB_Address),
    .SB_Rt          (SB_Rt),
    .SB_Byte        (SB_Byte),
    .Fwd_Hit        (Fwd_Hit),
    .Fwd_Data       (Fwd_Data),
    .Load_Stall     (Load_Stall),
    .Store_Stall    (Store_Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply request inputs and let combinational outputs settle.
  task automatic drive(input logic we, input logic re, input logic bt,
                       input logic [31:0] addr, input logic [31:0] data);
    MemWrite       = we;
    MemRead        = re;
    EXE_MEM_Byte   = bt;
    EXE_MEM_Result = addr;
    EXE_MEM_Rt     = data;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_count",       32'(dut.count), 32'd0);
    chk("rst_sb_memwrite", 32'(SB_MemWrite), 32'd0);
    chk("rst_sb_address",  SB_Address, 32'h0);
    chk("rst_sb_rt",       SB_Rt, 32'h0);
    chk("rst_sb_byte",     32'(SB_Byte), 32'd0);
    chk("rst_fwd_hit",     32'(Fwd_Hit), 32'd0);
    chk("rst_fwd_data",    Fwd_Data, 32'h0);
    chk("rst_load_stall",  32'(Load_Stall), 32'd0);
    chk("rst_store_stall", 32'(Store_Stall), 32'd0);

    // Single store retires the following cycle
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h11223344);
    tick();
    idle();
    chk("t1_memwrite", 32'(SB_MemWrite), 32'd1);
    chk("t1_address",  SB_Address, 32'h10);
    chk("t1_rt",       SB_Rt, 32'h11223344);
    chk("t1_byte",     32'(SB_Byte), 32'd0);
    chk("t1_count1",   32'(dut.count), 32'd1);
    tick();
    chk("t1_count0",   32'(dut.count), 32'd0);
    chk("t1_idle_wr",  32'(SB_MemWrite), 32'd0);

    // Memory busy with reads while four stores fill the queue
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      chk("t2_busy_wr",  32'(SB_MemWrite), 32'd0);
      chk("t2_no_sstl",  32'(Store_Stall), 32'd0);
      chk("t2_illegal_hit", 32'(Fwd_Hit | Load_Stall), 32'd0);
      tick();
    end
    chk("t2_full_count", 32'(dut.count), 32'd4);
    drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
    chk("t2_ld_wr",    32'(SB_MemWrite), 32'd0);
    chk("t2_ld_hit",   32'(Fwd_Hit), 32'd0);
    chk("t2_ld_stall", 32'(Load_Stall), 32'd0);
    chk("t2_ld_sstl",  32'(Store_Stall), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h110, 32'hEE);
    chk("t2_5th_sstl", 32'(Store_Stall), 32'd1);
    chk("t2_5th_wr",   32'(SB_MemWrite), 32'd0);
    tick();
    chk("t2_still4",   32'(dut.count), 32'd4);
    // Full with a same-cycle drain still stalls the store
    drive(1'b1, 1'b0, 1'b0, 32'h110, 32'hEE);
    chk("t2_cons_sstl", 32'(Store_Stall), 32'd1);
    chk("t2_cons_wr",   32'(SB_MemWrite), 32'd1);
    chk("t2_drain0_a",  SB_Address, 32'h100);
    chk("t2_drain0_d",  SB_Rt, 32'hA0);
    tick();
    idle();
    chk("t2_drain1_a",  SB_Address, 32'h104);
    chk("t2_drain1_d",  SB_Rt, 32'hA1);
    tick();
    chk("t2_drain2_a",  SB_Address, 32'h108);
    chk("t2_drain2_d",  SB_Rt, 32'hA2);
    tick();
    chk("t2_drain3_a",  SB_Address, 32'h10C);
    chk("t2_drain3_d",  SB_Rt, 32'hA3);
    chk("t2_drain3_wr", 32'(SB_MemWrite), 32'd1);
    tick();
    chk("t2_empty",     32'(dut.count), 32'd0);
    chk("t2_empty_wr",  32'(SB_MemWrite), 32'd0);

    // Exact-hit forwarding, word and byte, and high-address aliasing
    drive(1'b1, 1'b0, 1'b0, 32'h20, 32'hAABBCCDD);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("t3_lw_hit",   32'(Fwd_Hit), 32'd1);
    chk("t3_lw_data",  Fwd_Data, 32'hAABBCCDD);
    chk("t3_lw_stall", 32'(Load_Stall), 32'd0);
    chk("t3_lw_wr",    32'(SB_MemWrite), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h0);
    chk("t3_lb_hit",   32'(Fwd_Hit), 32'd1);
    chk("t3_lb_data",  Fwd_Data, 32'h000000DD);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'hFFFFFC20, 32'h0);
    chk("t3_alias_hit",  32'(Fwd_Hit), 32'd1);
    chk("t3_alias_data", Fwd_Data, 32'hAABBCCDD);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h21, 32'h0);
    chk("t3_part_stall", 32'(Load_Stall), 32'd1);
    chk("t3_part_hit",   32'(Fwd_Hit), 32'd0);
    chk("t3_part_wr",    32'(SB_MemWrite), 32'd1);
    tick();
    chk("t3_rel_stall",  32'(Load_Stall), 32'd0);
    chk("t3_rel_wr",     32'(SB_MemWrite), 32'd0);

    // Two stores to one word; youngest wins. Illegal read+write never forwards.
    drive(1'b1, 1'b1, 1'b0, 32'h30, 32'h1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h30, 32'h2);
    chk("t4_illegal_hit",   32'(Fwd_Hit), 32'd0);
    chk("t4_illegal_stall", 32'(Load_Stall), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
    chk("t4_young_hit",  32'(Fwd_Hit), 32'd1);
    chk("t4_young_data", Fwd_Data, 32'h2);
    tick();
    idle();
    chk("t4_fifo0", SB_Rt, 32'h1);
    tick();
    chk("t4_fifo1", SB_Rt, 32'h2);
    tick();
    chk("t4_empty", 32'(dut.count), 32'd0);

    // Word load over a buffered byte store stalls until it drains
    drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h55);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("t5_stall",   32'(Load_Stall), 32'd1);
    chk("t5_wr",      32'(SB_MemWrite), 32'd1);
    chk("t5_hit",     32'(Fwd_Hit), 32'd0);
    chk("t5_sb_byte", 32'(SB_Byte), 32'd1);
    chk("t5_sb_addr", SB_Address, 32'h40);
    chk("t5_sb_rt",   SB_Rt, 32'h55);
    tick();
    chk("t5_rel_stall", 32'(Load_Stall), 32'd0);
    chk("t5_rel_hit",   32'(Fwd_Hit), 32'd0);
    chk("t5_rel_wr",    32'(SB_MemWrite), 32'd0);

    // Youngest match is a different byte of the word even though an older
    // entry matches exactly: must stall, not forward the older one.
    drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h12345678);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h51, 32'h9A);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
    chk("t6_young_part_stall", 32'(Load_Stall), 32'd1);
    chk("t6_young_part_hit",   32'(Fwd_Hit), 32'd0);
    tick();
    chk("t6_still_stall", 32'(Load_Stall), 32'd1);
    tick();
    chk("t6_rel_stall", 32'(Load_Stall), 32'd0);
    chk("t6_count0",    32'(dut.count), 32'd0);
    idle();

    // Reset mid-operation discards buffered stores
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h60 + 32'(4 * i), 32'hC0 + 32'(i));
      tick();
    end
    chk("t7_pre_count", 32'(dut.count), 32'd3);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t7_count",   32'(dut.count), 32'd0);
    chk("t7_wr",      32'(SB_MemWrite), 32'd0);
    chk("t7_address", SB_Address, 32'h0);
    chk("t7_rt",      SB_Rt, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_no_write", 32'(SB_MemWrite), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write queue between the EXE/MEM pipeline register and the data memory. Stores leaving EXE/MEM are captured here and retire into memory one per cycle whenever the memory port is not serving a load, so a store never holds the pipeline unless the queue is full. Loads are checked against buffered stores: they are forwarded on an exact hit, and stalled on a partial overlap until the conflicting entries drain.

## Interface
Parameters:
- DEPTH, 4: number of entries, power of two, 2..16.
- ADDR_W, 10: byte-address width; matches the 1 KB data memory.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- EXE_MEM_Result  in  32  effective address; bits [ADDR_W-1:0] are used.
- EXE_MEM_Rt  in  32  store data.
- EXE_MEM_Byte  in  1  1 = byte access (sb/lb), 0 = word.
- MemWrite  in  1  store request from EXE/MEM.
- MemRead  in  1  load request from EXE/MEM.
- SB_MemWrite  out  1  write strobe to data memory.
- SB_Address  out  32  {22'b0, head address}.
- SB_Rt  out  32  head data.
- SB_Byte  out  1  head byte flag.
- Fwd_Hit  out  1  load satisfied from the buffer; the MEM result mux selects Fwd_Data.
- Fwd_Data  out  32  forwarded load value.
- Load_Stall  out  1  partial-overlap load; freeze IF/ID/EXE/MEM.
- Store_Stall  out  1  queue full; freeze IF/ID/EXE/MEM.

## Operation
- Entry fields: valid, addr[ADDR_W-1:0], data[31:0], byte. The queue is circular with head/tail pointers of log2(DEPTH) bits, and count runs 0..DEPTH.
- Enqueue: when MemWrite && !Store_Stall, the entry {addr, Rt, Byte} is written at tail, and tail and count advance.
- Store_Stall = MemWrite && (count == DEPTH). This check is conservative: a same-cycle drain does not free the slot.
- Drain: SB_MemWrite = (count != 0) && (!MemRead || Load_Stall). The SB_Address, SB_Rt and SB_Byte outputs always reflect the head entry. When SB_MemWrite is high, head advances and count decrements at the edge.
- Simultaneous enqueue and drain: count is unchanged, and both pointers advance.
- Load search (combinational, only when MemRead && !MemWrite):
  - A valid entry *matches* when entry.addr[ADDR_W-1:2] == load addr[ADDR_W-1:2].
  - The *youngest* match is the one closest to tail.
  - No match: Fwd_Hit=0 and Load_Stall=0. The memory serves the load.
  - Youngest match has an identical full address, and the load is a byte access: Fwd_Hit=1, Fwd_Data={24'b0, data[7:0]}. Memory places both byte and word stores' low byte at addr+3.
  - Youngest match has an identical full address, the load is a word access, and the entry is a word store: Fwd_Hit=1, Fwd_Data=data.
  - Youngest match has an identical full address, the load is a word access, and the entry is a byte store: Load_Stall=1.
  - Youngest match has the same word but a different full address: Load_Stall=1.
- During Load_Stall, draining continues. The stall releases combinationally once no conflicting entry remains.
- MemRead && MemWrite together is illegal. If it occurs, the store is enqueued, and Fwd_Hit=0, Load_Stall=0.
- Addresses are not range-checked. Address bits above ADDR_W-1 are ignored, which matches memory aliasing.

## Timing
- Reset values: count=0, head=tail=0, all valid=0. Outputs: SB_MemWrite=0, SB_Address=0, SB_Rt=0, SB_Byte=0, Fwd_Hit=0, Fwd_Data=0, Load_Stall=0, Store_Stall=0.
- Reset mid-operation discards all buffered stores without writing them.
- Store latency: a store enqueued at edge N is presented on SB_* during cycle N+1 at the earliest. Memory commits it in that same cycle.
- Fwd_Hit, Fwd_Data, Load_Stall and Store_Stall are combinational from the current inputs and queue state. They are valid before the memory's negedge read.
- Drain order is strictly FIFO. No store is merged or reordered.
- Throughput: one enqueue and one drain per cycle.

## Test plan
- Reset, then sw A=0x10, Rt=0x11223344 for one cycle. Required response: the next cycle shows SB_MemWrite=1, SB_Address=0x10, SB_Rt=0x11223344, SB_Byte=0; the cycle after that, count=0 and SB_MemWrite=0.
- Hold MemRead=1 to an unrelated address 0x200 while issuing 4 stores. Required response: SB_MemWrite stays 0, and a 5th store raises Store_Stall=1. Dropping MemRead drains one entry per cycle in issue order.
- Buffer sw 0x20/0xAABBCCDD, keep the memory busy, then lw 0x20. Required response: Fwd_Hit=1, Fwd_Data=0xAABBCCDD, Load_Stall=0. A following lb 0x20 returns Fwd_Data=0x000000DD.
- Buffer sw 0x30/0x1 then sw 0x30/0x2, then lw 0x30. Required response: the youngest entry wins, giving Fwd_Data=0x00000002.
- Buffer sb 0x40/0x55, then lw 0x40. Required response: Load_Stall=1 and SB_MemWrite=1 in the same cycle; the next cycle shows Load_Stall=0 and Fwd_Hit=0.
- Buffer 3 stores, then assert rst for one cycle. Required response: count=0, SB_MemWrite=0, and no memory writes occur afterwards.
